decode_issue_stage: RTL and testbench
=====================================

# decode_issue_stage

Parametrised decode/issue pipeline stage that sits between fetch and execute. It takes fields from the combinational `Decode` unit and reads operands from an internal register file. A per-register in-flight writer scoreboard interlocks read-after-write hazards, replacing the fixed stall-to-NOP behaviour of the previous generation. Valid/ready handshakes on both sides, a flush input for taken branches, and a stall performance counter complete the block.

## Interface
- `XLEN`, 32, data/address width.
- `NREGS`, 32, architectural registers; register 0 reads as zero.
- `IDW`, `$clog2(NREGS)`, register index width.
- `CTRL_W`, 16, width of the opaque control bundle (ALU op, mem/jump/branch flags) passed through unchanged.
- `CNT_W`, 2, width of each scoreboard counter; allows up to `2**CNT_W-1` writers in flight per register.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid` / `in_ready`  in/out  1  fetch-side handshake.
- `in_pc`  in  XLEN  address of this instruction.
- `in_imm`  in  XLEN  sign-extended immediate.
- `in_rs1`, `in_rs2`, `in_rd`  in  IDW  register indices.
- `in_uses_rs1`, `in_uses_rs2`, `in_reg_write`, `in_rs1_pc`, `in_rs2_neg`  in  1  decode flags.
- `in_ctrl`  in  CTRL_W  control bundle.
- `wb_enable`  in  1  writeback strobe.
- `wb_idx`  in  IDW  writeback register.
- `wb_data`  in  XLEN  writeback value.
- `flush`  in  1  kill the younger instructions (output entry plus the incoming instruction).
- `out_valid` / `out_ready`  out/in  1  execute-side handshake.
- `out_rs1_val`, `out_rs2_val`, `out_imm`, `out_jump_addr`  out  XLEN  operands.
- `out_rd`  out  IDW  destination register.
- `out_reg_write`  out  1  destination is written.
- `out_ctrl`  out  CTRL_W  control bundle.
- `stall_cycles`  out  32  count of hazard stall cycles, saturating.

## Operation
- **Register file**
  - `NREGS` x `XLEN`; register 0 is never written and always reads 0.
  - A write with `wb_enable && wb_idx!=0` lands on the clock edge.
  - A same-cycle read of `wb_idx` returns `wb_data` (write-through bypass).
- **Scoreboard**
  - One `CNT_W`-bit counter `cnt[r]` per register r≥1.
  - `issue_w` = an issue with `in_reg_write && in_rd!=0`. It increments `cnt[in_rd]`.
  - `wb_enable && wb_idx!=0` decrements `cnt[wb_idx]`.
  - An increment and a decrement on the same register in one cycle leave the counter unchanged.
  - A decrement at 0 is a protocol error: the counter stays at 0 (no wrap).
- **Hazards**
  - `busy(r)` = `r!=0 && cnt[r]!=0 && !(cnt[r]==1 && wb_enable && wb_idx==r)`.
  - `hazard` = `in_valid && ((in_uses_rs1 && busy(in_rs1)) || (in_uses_rs2 && busy(in_rs2)) || (issue_w && cnt[in_rd]==2**CNT_W-1))`.
- **Handshake**
  - `can_load` = `!out_valid || out_ready`.
  - `in_ready` = `flush || (can_load && !hazard)`.
  - Issue occurs when `in_valid && in_ready && !flush`.
- **Issue loads the output register with:**
  - `out_rs1_val` = `in_rs1_pc ? in_pc : rf[in_rs1]`.
  - `out_rs2_val` = `in_rs2_neg ? -rf[in_rs2] : rf[in_rs2]` (two's complement, mod 2^XLEN).
  - `out_jump_addr` = `in_pc + in_imm` (mod 2^XLEN).
  - `out_imm`, `out_rd`, `out_reg_write`, `out_ctrl` are copied from the inputs.
- **No issue:**
  - If `out_valid && out_ready`, then `out_valid` goes to 0.
  - Otherwise the output register holds all fields.
- **Flush**
  - The incoming instruction is consumed and dropped.
  - `out_valid` goes to 0 next cycle.
  - If the killed output entry had `out_reg_write && out_rd!=0`, `cnt[out_rd]` is decremented. This combines with writeback as a net ±.
  - Flush takes priority over `out_ready`.
- **Stall counter:** `stall_cycles` increments each cycle with `hazard && !flush`, and saturates at 2^32-1.

## Timing
- Reset (asynchronous, `rst_n`=0) sets:
  - `out_valid`=0;
  - all `out_*` data fields to 0;
  - every `cnt` to 0;
  - every register to 0;
  - `stall_cycles` to 0.
- Release of `rst_n` takes effect at the next clock edge. Reset asserted mid-operation discards in-flight state immediately.
- Latency: one cycle from issue to `out_valid`=1. Back-to-back issue sustains 1 instruction/cycle when there are no hazards and `out_ready`=1.
- Writeback-to-dependent issue: zero bubble when `wb_enable` arrives in the same cycle as the stalled reader.
- `in_ready` is combinational from `in_*`, `wb_*`, `flush`, `out_ready` and state. Outputs are registered only.
- Outputs stay stable while `out_valid && !out_ready`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream with `out_valid`=1 -> `out_valid`=0 at once, `stall_cycles`=0; the first issue after release reads register 5 as 0.
- **RAW stall and release:** issue writer to x3, then reader of x3 with `out_ready`=1 -> `in_ready`=0 and `stall_cycles` increments each cycle. Then `wb_enable`, x3=0x1234 -> reader issues that cycle and `out_rs1_val`=0x1234 next cycle.
- **Saturation:** with `CNT_W`=2, issue 3 writers to x7 with no writeback -> the 4th writer to x7 stalls. One writeback to x7 -> the 4th issues.
- **Flush:** writer to x9 sits in the output register, then `flush`=1 -> `out_valid`=0 next cycle, `cnt[9]`=0, and a following reader of x9 issues without stall.
- **Backpressure:** hold `out_ready`=0 for 4 cycles -> outputs unchanged and `in_ready`=0. Release -> a new instruction issues in the same cycle.
- **Arithmetic/x0:** `in_rs2_neg` with x2=1 -> `out_rs2_val`=0xFFFFFFFF. A writer to x0 does not stall a reader of x0, which reads 0. `in_pc`=0xFFFFFFFC with `in_imm`=8 -> `out_jump_addr`=0x4.

Source files
------------

// File: rtl/decode_issue_stage.sv
// decode_issue_stage: decode/issue pipeline stage between fetch and execute.
// Holds the architectural register file and a per-register in-flight writer
// scoreboard that interlocks RAW hazards. Valid/ready on both sides, a flush
// for taken branches, and a saturating hazard stall counter.
module decode_issue_stage #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int IDW    = $clog2(NREGS),
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [IDW-1:0]    in_rs1,
    input  logic [IDW-1:0]    in_rs2,
    input  logic [IDW-1:0]    in_rd,
    input  logic              in_uses_rs1,
    input  logic              in_uses_rs2,
    input  logic              in_reg_write,
    input  logic              in_rs1_pc,
    input  logic              in_rs2_neg,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              wb_enable,
    input  logic [IDW-1:0]    wb_idx,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_rs1_val,
    output logic [XLEN-1:0]   out_rs2_val,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_jump_addr,
    output logic [IDW-1:0]    out_rd,
    output logic              out_reg_write,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [31:0]       stall_cycles
);

    localparam int SUM_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0]   rf_q  [NREGS];
    logic [XLEN-1:0]   rf_d  [NREGS];
    logic [CNT_W-1:0]  cnt_q [NREGS];
    logic [CNT_W-1:0]  cnt_d [NREGS];

    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_rs1_val_q, out_rs1_val_d;
    logic [XLEN-1:0]   out_rs2_val_q, out_rs2_val_d;
    logic [XLEN-1:0]   out_imm_q, out_imm_d;
    logic [XLEN-1:0]   out_jump_addr_q, out_jump_addr_d;
    logic [IDW-1:0]    out_rd_q, out_rd_d;
    logic              out_reg_write_q, out_reg_write_d;
    logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
    logic [31:0]       stall_cycles_q, stall_cycles_d;

    logic              wb_hit;
    logic [XLEN-1:0]   rs1_data, rs2_data;
    logic              busy1, busy2, rd_w, hazard, can_load;
    logic              issue, issue_w, kill_w;

    // Next counter value: +1 for an issuing writer, -1 for each retire/kill,
    // clamped at zero so a stray writeback cannot wrap the counter.
    function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cur,
                                                  input logic inc,
                                                  input logic dec_a,
                                                  input logic dec_b);
        logic [SUM_W-1:0] up;
        logic [SUM_W-1:0] down;
        up   = {2'b00, cur} + SUM_W'(inc);
        down = SUM_W'(dec_a) + SUM_W'(dec_b);
        return (up >= down) ? CNT_W'(up - down) : '0;
    endfunction

    // Operand read with writeback bypass, hazard detection and handshake.
    always_comb begin
        wb_hit   = wb_enable && (wb_idx != '0);
        rs1_data = '0;
        rs2_data = '0;
        if (in_rs1 != '0) rs1_data = (wb_hit && wb_idx == in_rs1) ? wb_data : rf_q[in_rs1];
        if (in_rs2 != '0) rs2_data = (wb_hit && wb_idx == in_rs2) ? wb_data : rf_q[in_rs2];
        busy1    = (in_rs1 != '0) && (cnt_q[in_rs1] != '0) &&
                   !((cnt_q[in_rs1] == CNT_W'(1)) && wb_enable && (wb_idx == in_rs1));
        busy2    = (in_rs2 != '0) && (cnt_q[in_rs2] != '0) &&
                   !((cnt_q[in_rs2] == CNT_W'(1)) && wb_enable && (wb_idx == in_rs2));
        rd_w     = in_reg_write && (in_rd != '0);
        hazard   = in_valid && ((in_uses_rs1 && busy1) || (in_uses_rs2 && busy2) ||
                                (rd_w && (cnt_q[in_rd] == CNT_MAX)));
        can_load = !out_valid_q || out_ready;
        in_ready = flush || (can_load && !hazard);
        issue    = in_valid && in_ready && !flush;
        issue_w  = issue && rd_w;
        kill_w   = flush && out_valid_q && out_reg_write_q && (out_rd_q != '0);
    end

    // Register file writes and scoreboard counter updates; entry 0 stays zero.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            rf_d[r]  = rf_q[r];
            cnt_d[r] = cnt_q[r];
            if (r != 0) begin
                if (wb_hit && wb_idx == IDW'(r)) rf_d[r] = wb_data;
                cnt_d[r] = next_cnt(cnt_q[r],
                                    issue_w && (in_rd == IDW'(r)),
                                    wb_hit && (wb_idx == IDW'(r)),
                                    kill_w && (out_rd_q == IDW'(r)));
            end
        end
    end

    // Output register: flush kills, issue loads, a consumed entry empties.
    always_comb begin
        out_valid_d     = out_valid_q;
        out_rs1_val_d   = out_rs1_val_q;
        out_rs2_val_d   = out_rs2_val_q;
        out_imm_d       = out_imm_q;
        out_jump_addr_d = out_jump_addr_q;
        out_rd_d        = out_rd_q;
        out_reg_write_d = out_reg_write_q;
        out_ctrl_d      = out_ctrl_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (issue) begin
            out_valid_d     = 1'b1;
            out_rs1_val_d   = in_rs1_pc ? in_pc : rs1_data;
            out_rs2_val_d   = in_rs2_neg ? -rs2_data : rs2_data;
            out_imm_d       = in_imm;
            out_jump_addr_d = in_pc + in_imm;
            out_rd_d        = in_rd;
            out_reg_write_d = in_reg_write;
            out_ctrl_d      = in_ctrl;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Saturating count of cycles lost to hazards (flushed cycles excluded).
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (hazard && !flush && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 32'd1;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                rf_q[r]  <= '0;
                cnt_q[r] <= '0;
            end
            out_valid_q     <= 1'b0;
            out_rs1_val_q   <= '0;
            out_rs2_val_q   <= '0;
            out_imm_q       <= '0;
            out_jump_addr_q <= '0;
            out_rd_q        <= '0;
            out_reg_write_q <= 1'b0;
            out_ctrl_q      <= '0;
            stall_cycles_q  <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                rf_q[r]  <= rf_d[r];
                cnt_q[r] <= cnt_d[r];
            end
            out_valid_q     <= out_valid_d;
            out_rs1_val_q   <= out_rs1_val_d;
            out_rs2_val_q   <= out_rs2_val_d;
            out_imm_q       <= out_imm_d;
            out_jump_addr_q <= out_jump_addr_d;
            out_rd_q        <= out_rd_d;
            out_reg_write_q <= out_reg_write_d;
            out_ctrl_q      <= out_ctrl_d;
            stall_cycles_q  <= stall_cycles_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_rs1_val   = out_rs1_val_q;
    assign out_rs2_val   = out_rs2_val_q;
    assign out_imm       = out_imm_q;
    assign out_jump_addr = out_jump_addr_q;
    assign out_rd        = out_rd_q;
    assign out_reg_write = out_reg_write_q;
    assign out_ctrl      = out_ctrl_q;
    assign stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed testbench for decode_issue_stage with an expected-result queue.
module tb_decode_issue_stage;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int IDW    = 5;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc, in_imm;
    logic [IDW-1:0]    in_rs1, in_rs2, in_rd;
    logic              in_uses_rs1, in_uses_rs2, in_reg_write, in_rs1_pc, in_rs2_neg;
    logic [CTRL_W-1:0] in_ctrl;
    logic              wb_enable;
    logic [IDW-1:0]    wb_idx;
    logic [XLEN-1:0]   wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_rs1_val, out_rs2_val, out_imm, out_jump_addr;
    logic [IDW-1:0]    out_rd;
    logic              out_reg_write;
    logic [CTRL_W-1:0] out_ctrl;
    logic [31:0]       stall_cycles;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] jump;
        logic [4:0]  rd;
        logic        regw;
        logic [15:0] ctrl;
    } exp_t;

    exp_t        sb[$];
    exp_t        last_exp;
    logic [31:0] tb_rf [NREGS];
    logic [31:0] exp_stall;
    int          total = 0;
    int          bad   = 0;

    decode_issue_stage #(
        .XLEN(XLEN), .NREGS(NREGS), .IDW(IDW), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
        .in_reg_write(in_reg_write), .in_rs1_pc(in_rs1_pc), .in_rs2_neg(in_rs2_neg),
        .in_ctrl(in_ctrl),
        .wb_enable(wb_enable), .wb_idx(wb_idx), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_imm(out_imm), .out_jump_addr(out_jump_addr),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_ctrl(out_ctrl),
        .stall_cycles(stall_cycles)
    );

    // 100 MHz free-running clock
    always #5 clk = ~clk;

    // One comparison: counts it and reports any difference
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference register read including the same-cycle writeback bypass
    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_enable && wb_idx == idx) return wb_data;
        return tb_rf[idx];
    endfunction

    // Drive one instruction onto the fetch side
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic u1, input logic u2, input logic rw,
                                 input logic pcsel, input logic neg, input logic [15:0] ctrl);
        in_valid     = 1'b1;
        in_pc        = pc;
        in_imm       = imm;
        in_rs1       = rs1;
        in_rs2       = rs2;
        in_rd        = rd;
        in_uses_rs1  = u1;
        in_uses_rs2  = u2;
        in_reg_write = rw;
        in_rs1_pc    = pcsel;
        in_rs2_neg   = neg;
        in_ctrl      = ctrl;
    endtask

    // Pop the oldest expected entry and compare it with the output register
    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_rs1_val", out_rs1_val, e.rs1);
            check("out_rs2_val", out_rs2_val, e.rs2);
            check("out_imm", out_imm, e.imm);
            check("out_jump_addr", out_jump_addr, e.jump);
            check("out_rd", 32'(out_rd), 32'(e.rd));
            check("out_reg_write", 32'(out_reg_write), 32'(e.regw));
            check("out_ctrl", 32'(out_ctrl), 32'(e.ctrl));
            last_exp = e;
        end
    endtask

    // Output register must keep the last accepted entry under backpressure
    task automatic checkHold();
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_rs1", out_rs1_val, last_exp.rs1);
        check("hold_rs2", out_rs2_val, last_exp.rs2);
        check("hold_jump", out_jump_addr, last_exp.jump);
        check("hold_ctrl", 32'(out_ctrl), 32'(last_exp.ctrl));
    endtask

    // One clock cycle from a falling edge: check in_ready, record an expected
    // issue, advance, then check the stall counter and any issued entry.
    task automatic cycle(input logic exp_ready, input logic exp_hz);
        exp_t e;
        logic pushed;
        #1;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        pushed = exp_ready && in_valid && !flush;
        if (pushed) begin
            e.rs1  = in_rs1_pc ? in_pc : model_read(in_rs1);
            e.rs2  = in_rs2_neg ? (32'd0 - model_read(in_rs2)) : model_read(in_rs2);
            e.imm  = in_imm;
            e.jump = in_pc + in_imm;
            e.rd   = in_rd;
            e.regw = in_reg_write;
            e.ctrl = in_ctrl;
            sb.push_back(e);
        end
        if (exp_hz) exp_stall = exp_stall + 32'd1;
        @(posedge clk);
        @(negedge clk);
        if (wb_enable && wb_idx != 5'd0) tb_rf[wb_idx] = wb_data;
        if (pushed || flush) in_valid = 1'b0;
        wb_enable = 1'b0;
        flush     = 1'b0;
        check("stall_cycles", stall_cycles, exp_stall);
        if (pushed) checkOutput();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_pc = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_uses_rs1 = 1'b0; in_uses_rs2 = 1'b0; in_reg_write = 1'b0;
        in_rs1_pc = 1'b0; in_rs2_neg = 1'b0; in_ctrl = '0;
        wb_enable = 1'b0; wb_idx = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;
        exp_stall = 32'd0;
        for (int i = 0; i < NREGS; i++) tb_rf[i] = 32'd0;

        // Power-on reset values
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_stall", stall_cycles, 32'd0);
        check("rst_rs1_val", out_rs1_val, 32'd0);
        check("rst_jump", out_jump_addr, 32'd0);
        rst_n = 1'b1;

        // Mid-stream reset: writer to x5 in the output, x5 written, then reset
        $display("[TB] reset mid-stream");
        applyStimulus(32'h100, 32'h4, 5'd0, 5'd0, 5'd5, 0, 0, 1, 0, 0, 16'h0A01);
        cycle(1, 0);
        out_ready = 1'b0;
        wb_enable = 1'b1; wb_idx = 5'd5; wb_data = 32'h55;
        cycle(0, 0);
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_stall", stall_cycles, 32'd0);
        check("async_rst_rd", 32'(out_rd), 32'd0);
        exp_stall = 32'd0;
        for (int i = 0; i < NREGS; i++) tb_rf[i] = 32'd0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        applyStimulus(32'h200, 32'h0, 5'd5, 5'd0, 5'd6, 1, 0, 0, 0, 0, 16'h0B02);
        cycle(1, 0);

        // RAW stall on x3, released by a same-cycle writeback
        $display("[TB] RAW stall and release");
        applyStimulus(32'h300, 32'h0, 5'd0, 5'd0, 5'd3, 0, 0, 1, 0, 0, 16'h0C03);
        cycle(1, 0);
        applyStimulus(32'h304, 32'h8, 5'd3, 5'd0, 5'd4, 1, 0, 0, 0, 0, 16'h0C04);
        cycle(0, 1);
        cycle(0, 1);
        wb_enable = 1'b1; wb_idx = 5'd3; wb_data = 32'h1234;
        cycle(1, 0);

        // Scoreboard saturation on x7
        $display("[TB] scoreboard saturation");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h400 + 32'(i * 4), 32'h0, 5'd0, 5'd0, 5'd7, 0, 0, 1, 0, 0, 16'h0D00);
            cycle(1, 0);
        end
        applyStimulus(32'h40C, 32'h0, 5'd0, 5'd0, 5'd7, 0, 0, 1, 0, 0, 16'h0D04);
        cycle(0, 1);
        wb_enable = 1'b1; wb_idx = 5'd7; wb_data = 32'h70;
        cycle(0, 1);
        cycle(1, 0);
        for (int i = 0; i < 3; i++) begin
            wb_enable = 1'b1; wb_idx = 5'd7; wb_data = 32'h71 + 32'(i);
            cycle(1, 0);
        end

        // Flush kills a pending writer to x9 and the incoming reader
        $display("[TB] flush");
        out_ready = 1'b0;
        applyStimulus(32'h500, 32'h0, 5'd0, 5'd0, 5'd9, 0, 0, 1, 0, 0, 16'h0E01);
        cycle(1, 0);
        applyStimulus(32'h504, 32'h0, 5'd9, 5'd0, 5'd1, 1, 0, 0, 0, 0, 16'h0E02);
        flush = 1'b1;
        cycle(1, 0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        applyStimulus(32'h508, 32'h0, 5'd9, 5'd0, 5'd1, 1, 0, 0, 0, 0, 16'h0E03);
        cycle(1, 0);

        // Backpressure holds the output, release lets a new one in
        $display("[TB] backpressure");
        applyStimulus(32'h600, 32'h10, 5'd7, 5'd3, 5'd8, 1, 1, 0, 0, 0, 16'h0F01);
        cycle(1, 0);
        out_ready = 1'b0;
        applyStimulus(32'h700, 32'h20, 5'd5, 5'd0, 5'd8, 1, 0, 0, 0, 0, 16'h0F02);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0);
            checkHold();
        end
        out_ready = 1'b1;
        cycle(1, 0);

        // Negation, PC-relative rs1, jump wrap and x0 handling
        $display("[TB] arithmetic and x0");
        applyStimulus(32'h800, 32'h0, 5'd0, 5'd0, 5'd2, 0, 0, 1, 0, 0, 16'h1001);
        cycle(1, 0);
        wb_enable = 1'b1; wb_idx = 5'd2; wb_data = 32'h1;
        cycle(1, 0);
        applyStimulus(32'hFFFF_FFFC, 32'h8, 5'd0, 5'd2, 5'd10, 0, 1, 0, 1, 1, 16'h1002);
        cycle(1, 0);
        applyStimulus(32'h900, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 16'h1003);
        cycle(1, 0);
        applyStimulus(32'h904, 32'h0, 5'd0, 5'd0, 5'd11, 1, 1, 0, 0, 0, 16'h1004);
        cycle(1, 0);

        check("final_stall_total", stall_cycles, 32'd4);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
